// File: rtl/mips_muldiv_pkg.sv
// Shared mul/div encodings; decode maps funct 6'b011000..6'b011011 onto muldiv_op_t.
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate used for operand magnitudes and result sign fix.
module muldiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] out_val
);

    always_comb begin
        out_val = en ? (~in_val + WIDTH'(1)) : in_val;
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine producing {HI, LO}; WIDTH+1 cycles from start to done.
module hilo_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    muldiv_state_t        state_q, state_d;
    muldiv_op_t           op_q, op_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    muldiv_op_t           op_in;
    logic                 signed_op;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        op_in     = muldiv_op_t'(op);
        signed_op = op_is_signed(op_in);
        sign_a    = signed_op & op_a[WIDTH-1];
        sign_b    = signed_op & op_b[WIDTH-1];
    end

    // The most-negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (.en(sign_a), .in_val(op_a), .out_val(a_mag));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (.en(sign_b), .in_val(op_b), .out_val(b_mag));

    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .en(neg_res_q), .in_val(acc_q), .out_val(prod_fix)
    );
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .en(neg_res_q), .in_val(quo_q), .out_val(quo_fix)
    );
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .en(neg_rem_q), .in_val(rem_q[WIDTH-1:0]), .out_val(rem_fix)
    );

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_trial = div_shift - {2'b00, b_q};
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;

        unique case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    op_d      = op_in;
                    cnt_d     = '0;
                    a_d       = a_mag;
                    b_d       = b_mag;
                    acc_d     = {{WIDTH{1'b0}}, b_mag};
                    rem_d     = '0;
                    quo_d     = a_mag;
                    // Divide-by-zero keeps an all-ones quotient regardless of dividend sign.
                    neg_res_d = (sign_a ^ sign_b) & (op_b != '0);
                    neg_rem_d = sign_a;
                end
            end
            RUN: begin
                unique case (op_q)
                    MULT, MULTU: begin
                        acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                         : {1'b0, acc_q[2*WIDTH-1:1]};
                    end
                    DIV, DIVU: begin
                        rem_d = div_trial[WIDTH+1] ? div_shift[WIDTH:0] : div_trial[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
                    end
                endcase
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                unique case (op_q)
                    MULT, MULTU: result_d = prod_fix;
                    DIV, DIVU:   result_d = {rem_fix, quo_fix};
                endcase
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= MULT;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: arithmetic reference model checked every cycle plus directed vectors.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          busy;
    logic          done;
    logic [2*W-1:0] result;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle-level timing derived from the start/latency rules only.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_cnt = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_result = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_cnt    <= 0;
            m_pend   <= '0;
            m_result <= '0;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= W + 1;
                m_pend <= ref_result(op, op_a, op_b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_busy", 64'(busy), 64'(m_busy));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_result", result, m_result);
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o;
        op_a = a;
        op_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits from the current negedge for done; checks literal result, latency and busy span.
    task automatic wait_done(input string name, input logic [63:0] exp, input int exp_n);
        int n = 0;
        int bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, n);
        end else begin
            check({name, "_result"}, result, exp);
            check({name, "_latency"}, 64'(n), 64'(exp_n));
            check({name, "_busy_cycles"}, 64'(bc), 64'(exp_n));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        check("reset_result", result, 64'h0);
        rst_n = 1'b1;

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 64'hFFFF_FFFE_0000_0001, 33);
        launch(2'b00, 32'hFFFF_FFFD, 32'h7);
        wait_done("mult_neg", 64'hFFFF_FFFF_FFFF_FFEB, 33);
        launch(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_minmin", 64'h4000_0000_0000_0000, 33);
        launch(2'b10, 32'hFFFF_FFF9, 32'h2);
        wait_done("div_neg", 64'hFFFF_FFFF_FFFF_FFFD, 33);
        launch(2'b11, 32'h7, 32'h2);
        wait_done("divu_small", 64'h0000_0001_0000_0003, 33);
        launch(2'b11, 32'h1234, 32'h0);
        wait_done("divu_zero", 64'h0000_1234_FFFF_FFFF, 33);
        launch(2'b10, 32'hFFFF_FFFB, 32'h0);
        wait_done("div_zero_neg", 64'hFFFF_FFFB_FFFF_FFFF, 33);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 64'h0000_0000_8000_0000, 33);

        // start pulse in RUN with different operands must be ignored
        launch(2'b01, 32'h0001_0000, 32'h0001_0000);
        repeat (5) @(negedge clk);
        op = 2'b11;
        op_a = 32'h9;
        op_b = 32'h3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", 64'h0000_0001_0000_0000, 27);

        // back-to-back: start during DONE
        launch(2'b11, 32'd100, 32'd7);
        wait_done("b2b_first", 64'h0000_0002_0000_000E, 33);
        op = 2'b00;
        op_a = 32'hFFFF_FFFF;
        op_b = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second", 64'h0000_0000_0000_0001, 33);

        // asynchronous reset mid-divide
        launch(2'b10, 32'hFFFF_FF00, 32'h3);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'h0);
        check("async_rst_done", 64'(done), 64'h0);
        check("async_rst_result", result, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("post_rst_no_done", 64'(dn), 64'h0);
        check("post_rst_result", result, 64'h0);

        launch(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        wait_done("post_rst_mult", 64'h0000_0000_0000_0004, 33);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide engine that produces the 64-bit {HI, LO} value consumed by the HI/LO register write path. It executes MULT, MULTU, DIV and DIVU over multiple cycles. While working it holds `busy` for decode/stall logic, then pulses `done` with a stable `result` that the HI/LO write logic latches. It sits beside the single-cycle ALU in the execute stage.

## Interface
- `WIDTH`, default 32: operand width; `result` is 2*WIDTH.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, asynchronous and active-low.
- `start` input 1: request a new operation; accepted only in IDLE or DONE.
- `op` input 2: operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `op_a` input WIDTH: rs value (multiplicand or dividend). Sampled with `start`.
- `op_b` input WIDTH: rt value (multiplier or divisor). Sampled with `start`.
- `busy` output 1: operation in progress. Decode must stall MFHI, MFLO, MTHI, MTLO and mult/div while `busy` is high.
- `done` output 1: one-cycle pulse; `result` is valid in this cycle.
- `result` output 2*WIDTH: {HI, LO}.
  - Multiply: HI:LO is the full product.
  - Divide: HI is the remainder, LO is the quotient.

## Operation
- **States:** IDLE, RUN, FIX, DONE.
- **Reset:** state IDLE; `busy`=0; `done`=0; `result`=0; all internal registers 0.
- **IDLE or DONE with `start`=1:**
  - Capture `op`, |`op_a`|, |`op_b`| (magnitude only for signed ops), the result sign and the dividend sign.
  - Clear the iteration counter; go to RUN.
- **IDLE or DONE with `start`=0:** go to (or stay in) IDLE. `result` holds its last value.
- **RUN:** one iteration per cycle for WIDTH cycles; counter runs 0..WIDTH-1; go to FIX after the last iteration.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. Remainder register is WIDTH+1 bits; quotient is built LSB-first by shifting.
- **FIX:** apply sign correction and write `result`; go to DONE.
  - MULT: negate the product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
- **DONE:** `done`=1 for exactly one cycle; `busy`=0.
- **`start` in RUN or FIX:** ignored, with no side effects.
- **Divide by zero** (`op_b`=0), both DIV and DIVU: LO = all ones, HI = `op_a` unchanged. No trap.
- **Signed overflow** (DIV 0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm and must not be special-cased wrongly.
- **Magnitude of the most-negative value:** 0x80000000 must be handled as unsigned 2^31, so a WIDTH-bit unsigned magnitude suffices.

## Timing
- **Accept:** `start` is accepted at clock edge k.
- **Busy:** `busy` is high from after edge k through the cycle before edge k+WIDTH+1 (RUN plus FIX, i.e. WIDTH+1 cycles).
- **Done:** `done` is high between edges k+WIDTH+1 and k+WIDTH+2. Latency from start to `done` is WIDTH+1 cycles (33 at WIDTH=32).
- **Back-to-back:** `start` asserted during the DONE cycle is accepted at that edge, so the next operation sees no bubble.
- **Outputs:** `busy`, `done` and `result` are registered. No combinational path from inputs to outputs.
- **Reset mid-operation:** asynchronous reset immediately forces `busy`=0, `done`=0, `result`=0 and state IDLE. The aborted operation never produces `done`.

## Structure
- **Shared package `mips_muldiv_pkg`:**
  - enum `muldiv_op_t`: MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11.
  - enum `muldiv_state_t`: IDLE, RUN, FIX, DONE.
  - These are shared with decode, which maps funct codes 6'b011000–6'b011011 onto them.
- **Sub-module:** `muldiv_negate`, a parameterised conditional two's-complement negate. It is instantiated for operand magnitude and for product, quotient and remainder sign fix.
- **Everything else** lives in one module: FSM, counter and datapath registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `result`=0xFFFFFFFE_00000001; `done` exactly 33 cycles after the `start` edge; `busy` high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → `result`=0xFFFFFFFF_FFFFFFEB. MULT 0x80000000 × 0x80000000 → 0x40000000_00000000.
- DIV 0xFFFFFFF9 (−7) / 2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIVU 7 / 2 → HI=1, LO=3.
- DIVU 0x1234 / 0 → HI=0x00001234, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → HI=0, LO=0x80000000.
- `start` pulsed in RUN cycle 5 with different operands → ignored, original result returned. `start` held in the DONE cycle → second op accepted; second `done` arrives 33 cycles later.
- `reset` driven low 10 cycles into a DIV → `busy`, `done` and `result` go to 0 without waiting for a clock edge; no `done` after reset is released.
